// File: rtl/blk_f3a87d.sv
// blk_f3a87d: producer side of the OCI data-capture-trace interface.
// Packs 2-bit trace symbols LSB-first into 30-bit words. Words leave through a
// valid/ready output register. The block also sequences the end-of-test flags.
// Optional feature macro: LEMONDE_STREIT_OCI_DCT_PARITY_EN adds the registered
// dct_parity output, which is the XOR of the outgoing word.
//
// state  | meaning
// RUN    | accepting symbols, flush on request
// ENDING | no new symbols, draining accumulator and output word
// ENDED  | everything drained, sticky until reset
module blk_f3a87d #(
    parameter int MAX_SYMS = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sym_valid,
    input  logic [1:0]  sym_data,
    output logic        sym_ready,
    input  logic        flush,
    input  logic        end_req,
    output logic        dct_valid,
    input  logic        dct_ready,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        test_ending,
    output logic        test_has_ended
`ifdef LEMONDE_STREIT_OCI_DCT_PARITY_EN
    ,
    output logic        dct_parity
`endif
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] ENDING = 2'd1;
    localparam logic [1:0] ENDED  = 2'd2;

    localparam logic [3:0] MAX_CNT = 4'(MAX_SYMS);

    logic [1:0]  state_q, state_d;
    logic [29:0] acc_buf_q, acc_buf_d;
    logic [3:0]  acc_cnt_q, acc_cnt_d;
    logic        flush_pend_q, flush_pend_d;
    logic        out_valid_q, out_valid_d;
    logic [29:0] out_buf_q, out_buf_d;
    logic [3:0]  out_cnt_q, out_cnt_d;
    logic        out_par_q, out_par_d;

    logic        accept;
    logic        out_free;
    logic        flush_any;
    logic        transfer;
    logic [29:0] sym_shift;
    logic [29:0] new_buf;
    logic [3:0]  new_cnt;

    // Symbols are refused during reset, outside RUN, or while the accumulator is full.
    assign sym_ready = !reset && (state_q == RUN) && (acc_cnt_q < MAX_CNT);

    // Accumulate this cycle's symbol and decide whether the word moves to the output register.
    always_comb begin
        accept    = sym_valid && sym_ready;
        out_free  = !out_valid_q || dct_ready;
        sym_shift = 30'(sym_data) << {acc_cnt_q, 1'b0};
        new_buf   = accept ? (acc_buf_q | sym_shift) : acc_buf_q;
        new_cnt   = acc_cnt_q + {3'b000, accept};
        // ENDING behaves as a permanently pending flush.
        flush_any = (flush && (state_q == RUN)) || flush_pend_q || (state_q == ENDING);
        transfer  = out_free && ((new_cnt == MAX_CNT) || (flush_any && (new_cnt != 4'd0)));
    end

    // Next-state for the accumulator, the pending flush and the output word.
    always_comb begin
        acc_buf_d    = new_buf;
        acc_cnt_d    = new_cnt;
        flush_pend_d = flush_pend_q;
        out_valid_d  = out_valid_q;
        out_buf_d    = out_buf_q;
        out_cnt_d    = out_cnt_q;
        out_par_d    = out_par_q;
        if (transfer) begin
            acc_buf_d    = 30'd0;
            acc_cnt_d    = 4'd0;
            flush_pend_d = 1'b0;
            out_valid_d  = 1'b1;
            out_buf_d    = new_buf;
            out_cnt_d    = new_cnt;
            out_par_d    = ^new_buf;
        end else begin
            // An empty flush is dropped; a blocked one waits for the output register.
            if (flush && (state_q == RUN) && (new_cnt != 4'd0)) begin
                flush_pend_d = 1'b1;
            end
            if (dct_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // End-of-test sequencing; ENDED is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (end_req) begin
                    // Nothing left to drain: finish immediately.
                    if ((new_cnt == 4'd0) && !flush_pend_q && out_free) begin
                        state_d = ENDED;
                    end else begin
                        state_d = ENDING;
                    end
                end
            end
            ENDING: begin
                if ((acc_cnt_q == 4'd0) && !flush_pend_q && out_free) begin
                    state_d = ENDED;
                end
            end
            ENDED:   state_d = ENDED;
            default: state_d = RUN;
        endcase
    end

    // State registers; reset throws away any partial or unconsumed word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            acc_buf_q    <= 30'd0;
            acc_cnt_q    <= 4'd0;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_buf_q    <= 30'd0;
            out_cnt_q    <= 4'd0;
            out_par_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_buf_q    <= acc_buf_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= out_valid_d;
            out_buf_q    <= out_buf_d;
            out_cnt_q    <= out_cnt_d;
            out_par_q    <= out_par_d;
        end
    end

    assign dct_valid      = out_valid_q;
    assign dct_buffer     = out_buf_q;
    assign dct_count      = out_cnt_q;
    assign test_ending    = (state_q == ENDING);
    assign test_has_ended = (state_q == ENDED);

`ifdef LEMONDE_STREIT_OCI_DCT_PARITY_EN
    assign dct_parity = out_par_q;
`else
    logic unused_par;
    assign unused_par = out_par_q;
`endif

endmodule
